// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters,
// the arbiter and the data memory.
interface dmem_arbiter_if #(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32
);
    logic                  m0_req;
    logic                  m1_req;
    logic                  m0_we;
    logic                  m1_we;
    logic                  m0_lock;
    logic                  m1_lock;
    logic [Addr_Width-1:0] m0_addr;
    logic [Addr_Width-1:0] m1_addr;
    logic [Data_Width-1:0] m0_wdata;
    logic [Data_Width-1:0] m1_wdata;
    logic                  m0_gnt;
    logic                  m1_gnt;
    logic                  m0_rvalid;
    logic                  m1_rvalid;
    logic [Data_Width-1:0] rdata;
    logic                  mem_we;
    logic [Addr_Width-1:0] mem_addr;
    logic [Data_Width-1:0] mem_wdata;
    logic [Data_Width-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  m0_req, m1_req,
        input  m0_we, m1_we,
        input  m0_lock, m1_lock,
        input  m0_addr, m1_addr,
        input  m0_wdata, m1_wdata,
        output m0_gnt, m1_gnt,
        output m0_rvalid, m1_rvalid,
        output rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus the memory read-data source.
    modport master (
        output m0_req, m1_req,
        output m0_we, m1_we,
        output m0_lock, m1_lock,
        output m0_addr, m1_addr,
        output m0_wdata, m1_wdata,
        input  m0_gnt, m1_gnt,
        input  m0_rvalid, m1_rvalid,
        input  rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin on ties,
// optional locked ownership with a bounded hand-over.
module dmem_arbiter #(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32,
    parameter int Max_Lock   = 16
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // The grant that enters OWNn is the first locked grant;
    // the counter then tallies the grants made inside OWNn,
    // so Max_Lock total grants are reached at Max_Lock-1.
    localparam logic [7:0] LockLast = 8'(Max_Lock - 1);

    state_t                state_q;
    state_t                state_d;
    logic                  last_gnt_q;
    logic                  last_gnt_d;
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic [Data_Width-1:0] rdata_q;
    logic [Data_Width-1:0] rdata_d;
    logic                  rvalid0_q;
    logic                  rvalid0_d;
    logic                  rvalid1_q;
    logic                  rvalid1_d;
    logic                  gnt0;
    logic                  gnt1;
    logic [7:0]            cnt_inc;

    // Saturating increment for the lock counter.
    assign cnt_inc = (cnt_q == LockLast) ? cnt_q : cnt_q + 8'd1;

    // Grant selection, next state, lock count and round-robin pointer.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.m0_req && bus.m1_req) begin
                    gnt0 = last_gnt_q;
                    gnt1 = !last_gnt_q;
                end else begin
                    gnt0 = bus.m0_req;
                    gnt1 = bus.m1_req;
                end
                if (gnt0 && bus.m0_lock) begin
                    state_d = OWN0;
                end else if (gnt1 && bus.m1_lock) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!bus.m0_req) begin
                    gnt1 = bus.m1_req;
                end else if (cnt_q == LockLast && bus.m1_req) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                    if (bus.m0_lock) begin
                        state_d = OWN0;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            OWN1: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!bus.m1_req) begin
                    gnt0 = bus.m0_req;
                end else if (cnt_q == LockLast && bus.m0_req) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                    if (bus.m1_lock) begin
                        state_d = OWN1;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    // Memory request mux; bus is parked at zero with no grant.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt0) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
        end else if (gnt1) begin
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
        end
    end

    // Read response: capture on a granted read, hold otherwise.
    always_comb begin
        rvalid0_d = gnt0 && !bus.m0_we;
        rvalid1_d = gnt1 && !bus.m1_we;
        rdata_d   = rdata_q;
        if (rvalid0_d || rvalid1_d) begin
            rdata_d = bus.mem_rdata;
        end
    end

    // State and response registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push
// expected grants/reads, a negedge monitor pops and compares.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.Data_Width(DW), .Addr_Width(AW)) bus ();

    dmem_arbiter #(
        .Data_Width(DW),
        .Addr_Width(AW),
        .Max_Lock  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic drive_zero();
        bus.m0_req    = 1'b0;
        bus.m1_req    = 1'b0;
        bus.m0_we     = 1'b0;
        bus.m1_we     = 1'b0;
        bus.m0_lock   = 1'b0;
        bus.m1_lock   = 1'b0;
        bus.m0_addr   = '0;
        bus.m1_addr   = '0;
        bus.m0_wdata  = '0;
        bus.m1_wdata  = '0;
        bus.mem_rdata = '0;
    endtask

    // exp_g: 0 = no grant, 1 = m0, 2 = m1 (hand-derived).
    task automatic cyc(input logic r0, input logic w0,
                       input logic l0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0,
                       input logic r1, input logic w1,
                       input logic l1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1,
                       input logic [DW-1:0] mrd,
                       input int exp_g);
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        bus.m0_req    = r0;
        bus.m0_we     = w0;
        bus.m0_lock   = l0;
        bus.m0_addr   = a0;
        bus.m0_wdata  = d0;
        bus.m1_req    = r1;
        bus.m1_we     = w1;
        bus.m1_lock   = l1;
        bus.m1_addr   = a1;
        bus.m1_wdata  = d1;
        bus.mem_rdata = mrd;
        if (exp_g == 1) begin
            g.id = 1'b0; g.we = w0; g.addr = a0; g.wdata = d0;
            gq.push_back(g);
            if (!w0) begin
                r.id = 1'b0; r.data = mrd;
                rq.push_back(r);
            end
        end else if (exp_g == 2) begin
            g.id = 1'b1; g.we = w1; g.addr = a1; g.wdata = d1;
            gq.push_back(g);
            if (!w1) begin
                r.id = 1'b1; r.data = mrd;
                rq.push_back(r);
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_zero();
        #1;
        check("rst_m0_rvalid", bus.m0_rvalid, 0);
        check("rst_m1_rvalid", bus.m1_rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        gq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents this cycle.
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("gnt_onehot", bus.m0_gnt & bus.m1_gnt, 0);
                if (bus.m0_gnt || bus.m1_gnt) begin
                    if (gq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_gnt: got m0=%0b m1=%0b expected none",
                                 bus.m0_gnt, bus.m1_gnt);
                    end else begin
                        g = gq.pop_front();
                        check("gnt_id", bus.m1_gnt, g.id);
                        check("mem_we", bus.mem_we, g.we);
                        check("mem_addr", bus.mem_addr, g.addr);
                        check("mem_wdata", bus.mem_wdata, g.wdata);
                    end
                end else begin
                    check("idle_mem_we", bus.mem_we, 0);
                    check("idle_mem_addr", bus.mem_addr, 0);
                    check("idle_mem_wdata", bus.mem_wdata, 0);
                end
                if (bus.m0_rvalid || bus.m1_rvalid) begin
                    check("rvalid_onehot",
                          bus.m0_rvalid & bus.m1_rvalid, 0);
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b expected none",
                                 bus.m0_rvalid, bus.m1_rvalid);
                    end else begin
                        r = rq.pop_front();
                        check("rvalid_id", bus.m1_rvalid, r.id);
                        check("rdata", bus.rdata, r.data);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        drive_zero();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("init_m0_rvalid", bus.m0_rvalid, 0);
        check("init_m1_rvalid", bus.m1_rvalid, 0);
        check("init_rdata", bus.rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Both request, no lock: m0, m1, m0, m1.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 32'h100 + i, 0,
                1, 0, 0, 32'h200 + i, 0,
                32'h1111_0000 + i, (i % 2 == 0) ? 1 : 2);
        end
        idle();
        idle();

        // Fresh reset, then a lone m0 read.
        do_reset();
        cyc(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0,
            32'hCAFE_0001, 1);
        idle();
        idle();
        #3;
        check("rdata_hold", bus.rdata, 32'hCAFE_0001);

        // m1 locked writes against m0 reads: 4x m1, 1x m0.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 32'h400 + i, 0,
                1, 1, 1, 32'h300 + i, 32'hA000 + i,
                32'h2222_0000 + i, (i < 4) ? 2 : 1);
        end
        cyc(1, 0, 0, 32'h410, 0, 1, 1, 0, 32'h310, 32'hA010,
            32'h2222_0010, 2);
        cyc(1, 0, 0, 32'h411, 0, 1, 1, 0, 32'h311, 32'hA011,
            32'h2222_0011, 1);
        idle();

        // m1 lock alone saturates, then m0 still gets hand-over.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 1, 32'h500 + i, 0,
                32'h3333_0000 + i, 2);
        end
        cyc(1, 0, 0, 32'h600, 0, 1, 0, 1, 32'h506, 0,
            32'h3333_0006, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h507, 0,
            32'h3333_0007, 2);
        idle();

        // m0 write: no read response.
        cyc(1, 1, 0, 32'h20, 32'h1234, 0, 0, 0, 0, 0,
            32'hDEAD_BEEF, 1);
        idle();

        // m0 lock, then drops req while m1 waits.
        cyc(1, 0, 1, 32'h700, 0, 0, 0, 0, 0, 0,
            32'h4444_0000, 1);
        cyc(1, 0, 1, 32'h701, 0, 1, 0, 0, 32'h800, 0,
            32'h4444_0001, 1);
        cyc(0, 0, 1, 32'h702, 0, 1, 0, 0, 32'h801, 0,
            32'h4444_0002, 2);
        cyc(1, 0, 0, 32'h703, 0, 1, 0, 0, 32'h802, 0,
            32'h4444_0003, 1);
        cyc(1, 0, 0, 32'h704, 0, 1, 0, 0, 32'h803, 0,
            32'h4444_0004, 2);
        idle();

        // Reset while owning with a read response pending.
        cyc(1, 0, 1, 32'h900, 0, 0, 0, 0, 0, 0,
            32'h5555_0000, 1);
        cyc(1, 0, 1, 32'h901, 0, 1, 0, 0, 32'hA00, 0,
            32'h5555_0001, 1);
        do_reset();
        cyc(1, 0, 0, 32'h902, 0, 1, 0, 0, 32'hA01, 0,
            32'h5555_0002, 1);
        cyc(1, 0, 0, 32'h903, 0, 1, 0, 0, 32'hA02, 0,
            32'h5555_0003, 2);
        idle();
        idle();
        idle();
        #3;
        check("grant_queue_empty", gq.size(), 0);
        check("read_queue_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: Data_Width, 32, data bus width.
REQ-002 Parameter: Addr_Width, 32, address bus width.
REQ-003 Parameter: Max_Lock, 16, max consecutive locked grants before forced hand-over (range 2..255).
REQ-004 Ports SHALL be, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  access request from requester 0 (CPU) and requester 1 (debug/DMA).
- m0_we, m1_we  in  1  write enable; 0 means read.
- m0_lock, m1_lock  in  1  request to keep ownership on following cycles.
- m0_addr, m1_addr  in  Addr_Width  byte address.
- m0_wdata, m1_wdata  in  Data_Width  write data.
- m0_gnt, m1_gnt  out  1  combinational grant for the current cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid, registered.
- rdata  out  Data_Width  registered read data, shared by both requesters.
- mem_we  out  1  write enable to the data memory.
- mem_addr  out  Addr_Width  address to the data memory.
- mem_wdata  out  Data_Width  write data to the data memory.
- mem_rdata  in  Data_Width  combinational read data from the data memory.

Function
REQ-005 SHALL grant at most one requester per cycle; m0_gnt and m1_gnt SHALL never both be 1.
REQ-006 A grant SHALL be issued only in a cycle where that requester's req is 1; gnt SHALL have zero cycles of latency from req.
REQ-007 When no requester is granted, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-008 Granted requester's we/addr/wdata SHALL drive mem_we/mem_addr/mem_wdata in the same cycle; the write commits at that clock edge.
REQ-009 Granted read: rdata SHALL capture mem_rdata at the edge, and that requester's rvalid SHALL be 1 for exactly the next cycle; rdata SHALL hold otherwise.
REQ-010 FSM states SHALL be IDLE, OWN0 and OWN1.
REQ-011 IDLE, one req: grant that requester.
REQ-012 IDLE, both req: grant the requester not granted last (round-robin pointer last_gnt).
REQ-013 The granted requester n with lock=1 SHALL move the FSM to OWNn; otherwise the FSM SHALL stay in IDLE.
REQ-014 OWNn SHALL grant only requester n while n keeps req=1; other requests SHALL wait, with no gnt.
REQ-015 OWNn SHALL return to IDLE at the edge where n has req=0 or lock=0.
REQ-016 A lock counter SHALL count consecutive grants in OWNn, clearing on entry to OWNn.
REQ-017 When the counter reaches Max_Lock and the other requester has req=1:
- the other requester SHALL be granted for one cycle;
- the FSM SHALL go to IDLE, with last_gnt set to the other requester.
If the other requester has req=0, the counter SHALL saturate and ownership SHALL continue.
REQ-018 last_gnt SHALL update on every granted cycle.
REQ-019 A requester dropping req mid-lock SHALL take effect that cycle: no gnt and no memory access.

Reset
REQ-020 While reset=0, the following SHALL hold, independent of clk:
- FSM = IDLE, lock counter = 0, last_gnt = 1 (m0 wins the first tie);
- rdata = 0, m0_rvalid = 0, m1_rvalid = 0.
REQ-021 An access in flight when reset asserts SHALL be discarded, with no rvalid after reset release.
REQ-022 After reset deasserts, the first cycle SHALL arbitrate normally per REQ-011/012.

Verification
REQ-023 Reset then m0 read only: m0_req=1, m0_we=0, addr=0x10, mem_rdata=0xCAFE0001 -> m0_gnt=1 same cycle; next cycle rdata=0xCAFE0001 and m0_rvalid=1.
REQ-024 Both req, no lock, 4 cycles -> grants m0, m1, m0, m1; never both gnt.
REQ-025 m1 lock with Max_Lock=4 and m0 requesting continuously -> m1 granted 4 cycles, then m0 for 1 cycle, then round-robin resumes.
REQ-026 m0 write: addr=0x20, wdata=0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 in the grant cycle; rvalid stays 0.
REQ-027 reset=0 asserted mid-OWN0 with a read pending -> rvalid=0 and rdata=0 immediately; after release with both req, m0 is granted first.
REQ-028 m0 lock, then m0_req drops while m1_req=1 -> m1 granted in that same cycle; FSM returns to IDLE.
